mux_scan_sequencer: RTL
=======================

Name: mux_scan_sequencer

Overview:
- Upstream/downstream companion to the team's 4:1 select mux.
- Drives the mux's 2-bit select through channels 0..3, holding each channel for DWELL cycles.
- Samples the mux output bit at the end of each dwell and presents all four captured bits as one 4-bit word with a single-cycle valid strobe.
- Sits between the control logic issuing scan requests and the 4:1 mux datapath.

Parameters:
- DWELL, 4: clock cycles select is held per channel; legal range 1..2**DWELL_W-1.
- DWELL_W, 4: width of the internal dwell counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  scan request, sampled only in IDLE.
- q_in  input  1  mux output bit for the channel currently selected.
- select  output  2  channel select to the mux (registered).
- busy  output  1  high while a scan is in progress (state SCAN).
- sample  output  4  captured word; bit i = q_in sampled while select==i.
- valid  output  1  one-cycle strobe; sample holds a new word.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE; select=2'b00; busy=0; valid=0; sample=4'b0000.
  - Dwell counter and internal shadow register = 0.
  - Applies immediately, including mid-scan. The partial scan is discarded, and no valid is produced for it.
- State register: IDLE, SCAN, DONE. All outputs are registered; none is a combinational function of inputs.
- IDLE:
  - select=00, busy=0, valid=0.
  - On an edge with start=1: go to SCAN; cnt=0; select=00; busy=1.
- SCAN:
  - Each edge: cnt increments.
  - On an edge where cnt==DWELL-1:
    - shadow[select] <= q_in; cnt <= 0.
    - If select<3: select <= select+1.
    - If select==3: go to DONE; sample <= {q_in, shadow[2:0]}; valid <= 1; busy <= 0; select <= 00.
- DONE:
  - Lasts exactly one cycle with valid=1; next edge goes to IDLE with valid <= 0.
- Capture point: q_in is sampled on the last edge of each dwell. The mux therefore has DWELL-1 full cycles to settle after each select change; with DWELL=1 it has only the same-cycle path.
- Latency: start accepted at edge E0 → busy high from E0 to E0+4*DWELL; valid high for the cycle after edge E0+4*DWELL.
- Minimum start-to-start spacing is 4*DWELL+2 cycles (one cycle in DONE, one in IDLE).
- start is ignored in SCAN and DONE; no queuing.
- sample holds its value between scans and changes only on the final-capture edge.
- Counter wrap: cnt never exceeds DWELL-1; DWELL values outside the legal range are unsupported.
- Simultaneous events: reset dominates everything. A start in the same cycle as DONE is ignored.

Optional Feature:
- Macro: SCAN_AUTORESTART_EN.
- Defined:
  - DONE checks start. If start=1, the next edge goes directly to SCAN (select=00, cnt=0, busy=1, valid<=0), skipping IDLE.
  - Back-to-back scans repeat every 4*DWELL+1 cycles while start is held high.
- Not defined: DONE always returns to IDLE; a held start restarts only from IDLE, so the period is 4*DWELL+2.

Test Plan:
- Reset with start=0 → select=00, busy=0, valid=0, sample=0000. Assert reset mid-scan (after channel 1 capture) → all outputs return to reset values immediately, and no valid is seen afterwards.
- DWELL=4, mux model d=4'b1010, one-cycle start pulse at E0 → select steps 00,01,10,11, each held 4 cycles; valid high exactly one cycle after E0+16; sample=4'b1010; busy=0 at that point.
- DWELL=4, d changed from 4'b1010 to 4'b0101 during channel 2's dwell before its last edge → sample=4'b0110 (bit2 takes the new value, bit0/bit1 keep the old, bit3 takes the new).
- start pulsed repeatedly during SCAN and during DONE → ignored: one valid only, select sequence unchanged, no extra scan.
- DWELL=1, d=4'b1111, single start → valid one cycle after E0+4, sample=4'b1111.
- start held high for 3 scans, DWELL=2 → valid period is 10 cycles without SCAN_AUTORESTART_EN and 9 cycles with it.

Source files
------------

// File: rtl/mux_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer_if
// Bundles the scan request, the mux feedback bit and the captured-word outputs
// of mux_scan_sequencer.
//   start  : scan request from control logic
//   q_in   : mux output bit for the currently selected channel
//   select : 2-bit channel select toward the 4:1 mux
//   busy   : scan in progress
//   sample : captured 4-bit word (bit i taken while select==i)
//   valid  : one-cycle strobe, sample holds a new word
// master : control logic / mux side (drives start and q_in)
// slave  : the sequencer
// -----------------------------------------------------------------------------
interface mux_scan_sequencer_if;
    logic       start;
    logic       q_in;
    logic [1:0] select;
    logic       busy;
    logic [3:0] sample;
    logic       valid;

    modport master (
        output start,
        output q_in,
        input  select,
        input  busy,
        input  sample,
        input  valid
    );

    modport slave (
        input  start,
        input  q_in,
        output select,
        output busy,
        output sample,
        output valid
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
// Steps a 4:1 mux select through channels 0..3, holding each for DWELL cycles,
// samples the mux output on the last edge of every dwell and publishes the four
// captured bits as one word with a single-cycle valid strobe.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : mux_scan_sequencer_if.slave (start, q_in in; select, busy,
//            sample, valid out -- all outputs registered)
//
// Parameters:
//   DWELL   : cycles select is held per channel (1 .. 2**DWELL_W-1)
//   DWELL_W : width of the dwell counter
//
// Build option:
//   SCAN_AUTORESTART_EN : when defined, a start seen in DONE goes straight back
//                         to SCAN, giving back-to-back scans every 4*DWELL+1
//                         cycles. Otherwise DONE always returns to IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; select parked at channel 0
// SCAN  | stepping channels, dwell counter running, busy high
// DONE  | one cycle with valid high; sample holds the new word
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
    parameter int DWELL   = 4,
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mux_scan_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);
    localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

    state_t             state_q,  state_d;
    logic [DWELL_W-1:0] cnt_q,    cnt_d;
    logic [1:0]         sel_q,    sel_d;
    // Channels 0..2 only; channel 3 goes straight from q_in into the word.
    logic [2:0]         shadow_q, shadow_d;
    logic [3:0]         sample_q, sample_d;
    logic               busy_q,   busy_d;
    logic               valid_q,  valid_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_d  = 2'd0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            ST_SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sel_q != 2'd3) begin
                        shadow_d[sel_q] = bus.q_in;
                        sel_d           = sel_q + 2'd1;
                    end else begin
                        state_d  = ST_DONE;
                        sample_d = {bus.q_in, shadow_q};
                        valid_d  = 1'b1;
                        busy_d   = 1'b0;
                        sel_d    = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
`ifdef SCAN_AUTORESTART_EN
                if (bus.start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = 2'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            shadow_q <= 3'd0;
            sample_q <= 4'd0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.select = sel_q;
    assign bus.busy   = busy_q;
    assign bus.sample = sample_q;
    assign bus.valid  = valid_q;

endmodule
